// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// mul_share_arbiter : round-robin sharing of one start/valid/busy multiplier
// among N_REQ requesters. Optional watchdog: define MUL_ARB_WATCHDOG_EN.
// Revision: 1.0
// ============================================================================
module mul_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_start,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic [N_REQ-1:0]         req_busy,
  output logic [N_REQ-1:0]         req_valid,
  output logic                     req_err,
  output logic [WIDTH-1:0]         res,
  output logic [WIDTH-1:0]         unit_a,
  output logic [WIDTH-1:0]         unit_b,
  output logic                     unit_start,
  input  logic                     unit_valid,
  input  logic                     unit_busy,
  input  logic [WIDTH-1:0]         unit_res
);

  localparam int IDXW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("mul_share_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [N_REQ-1:0]  pending;
  logic [IDXW-1:0]   owner;
  logic [IDXW-1:0]   rr_ptr;
  logic [WIDTH-1:0]  op_a [N_REQ];
  logic [WIDTH-1:0]  op_b [N_REQ];

  logic              grant_found;
  logic [IDXW-1:0]   grant_idx;
  logic [IDXW:0]     scan_sum;
  logic [IDXW-1:0]   scan_idx;
  logic              grant;
  logic              done_ok;
  logic              timeout;
  logic              finish;
  logic [N_REQ-1:0]  accept;
  logic [N_REQ-1:0]  grant_mask;
  logic [N_REQ-1:0]  owner_mask;

  // First pending requester at or after rr_ptr, wrapping past N_REQ-1
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (IDXW+1)'(k);
      if (scan_sum >= (IDXW+1)'(N_REQ)) begin
        scan_sum = scan_sum - (IDXW+1)'(N_REQ);
      end
      scan_idx = scan_sum[IDXW-1:0];
      if (!grant_found && pending[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign grant      = (state == IDLE) && grant_found && !unit_busy;
  assign done_ok    = (state == WAIT) && unit_valid;
  assign finish     = done_ok || timeout;
  assign accept     = req_start & ~req_busy;
  assign grant_mask = grant ? (N_REQ'(1) << grant_idx) : '0;
  assign owner_mask = N_REQ'(1) << owner;

`ifdef MUL_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if (state == WAIT) begin
      wd_cnt <= wd_cnt + CW'(1);
    end else begin
      wd_cnt <= '0;
    end
  end

  // Fires on the TIMEOUT-th WAIT cycle; a real result in that cycle still wins
  assign timeout = (state == WAIT) && !unit_valid && (wd_cnt == CW'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    unit_start = 1'b0;
    case (state)
      IDLE:    if (grant) state_nxt = ISSUE;
      ISSUE: begin
        unit_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT:    if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_busy[i] = pending[i] || ((state != IDLE) && (owner == IDXW'(i)));
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        op_a[i] <= '0;
        op_b[i] <= '0;
      end else if (accept[i]) begin
        op_a[i] <= req_a[i*WIDTH +: WIDTH];
        op_b[i] <= req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pending   <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      unit_a    <= '0;
      unit_b    <= '0;
      res       <= '0;
      req_valid <= '0;
      req_err   <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= (pending & ~grant_mask) | accept;
      if (grant) begin
        owner  <= grant_idx;
        unit_a <= op_a[grant_idx];
        unit_b <= op_b[grant_idx];
      end
      if (done_ok) begin
        res <= unit_res;
      end else if (timeout) begin
        res <= '0;
      end
      if (finish) begin
        rr_ptr <= (owner == IDXW'(N_REQ - 1)) ? '0 : owner + IDXW'(1);
      end
      req_valid <= finish ? owner_mask : '0;
      req_err   <= timeout;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
`default_nettype none
// Directed self-checking bench for mul_share_arbiter with a behavioural multiplier unit.
module tb_mul_share_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     req_start = '0;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic [N-1:0]     req_busy;
  logic [N-1:0]     req_valid;
  logic             req_err;
  logic [W-1:0]     res;
  logic [W-1:0]     unit_a;
  logic [W-1:0]     unit_b;
  logic             unit_start;
  logic             unit_valid = 1'b0;
  logic             unit_busy = 1'b0;
  logic [W-1:0]     unit_res = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int unit_lat  = 3;
  bit unit_hang = 1'b0;

  always #5 clk = ~clk;

  mul_share_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .req_start(req_start), .req_a(req_a), .req_b(req_b),
    .req_busy(req_busy), .req_valid(req_valid), .req_err(req_err), .res(res),
    .unit_a(unit_a), .unit_b(unit_b), .unit_start(unit_start),
    .unit_valid(unit_valid), .unit_busy(unit_busy), .unit_res(unit_res)
  );

  // Multiplier unit model: result pulse unit_lat cycles after unit_start
  initial begin
    int cnt;
    logic [W-1:0] pa, pb;
    cnt = 0; pa = '0; pb = '0;
    forever begin
      @(negedge clk);
      unit_valid = 1'b0;
      if (reset !== 1'b1) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0 && !unit_hang) begin
            unit_valid = 1'b1;
            unit_res   = pa * pb;
          end
        end
        if (unit_start === 1'b1) begin
          pa = unit_a; pb = unit_b; cnt = unit_lat;
        end
      end
    end
  end

  task automatic set_ops(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; req_start = '0; unit_busy = 1'b0; unit_hang = 1'b0; unit_lat = 3;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({req_busy, req_valid, req_err, res, unit_a, unit_b, unit_start} !== '0)
      begin n_fail++; $display("FAIL reset_outputs: busy=%b valid=%b err=%b res=%0d a=%0d b=%0d start=%b, expected all 0",
        req_busy, req_valid, req_err, res, unit_a, unit_b, unit_start); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({req_busy, req_valid, unit_start} !== '0)
      begin n_fail++; $display("FAIL reset_idle: busy=%b valid=%b start=%b, expected 0", req_busy, req_valid, unit_start); end
  endtask

  task automatic test_single();
    @(negedge clk);
    set_ops(0, 6, 7); req_start = 4'b0001;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      req_start = '0;
      if (k == 1) begin
        n_checks++;
        if (req_busy !== 4'b0001 || unit_start !== 1'b0)
          begin n_fail++; $display("FAIL single_pending: busy=%b start=%b, expected 0001/0", req_busy, unit_start); end
      end
      if (k == 2) begin
        n_checks++;
        if (unit_start !== 1'b1 || unit_a !== 32'd6 || unit_b !== 32'd7)
          begin n_fail++; $display("FAIL single_issue: start=%b a=%0d b=%0d, expected 1/6/7", unit_start, unit_a, unit_b); end
      end
      if (k == 5) begin
        n_checks++;
        if (req_valid !== 4'b0000 || req_busy !== 4'b0001)
          begin n_fail++; $display("FAIL single_wait: valid=%b busy=%b, expected 0000/0001", req_valid, req_busy); end
      end
      if (k == 6) begin
        n_checks++;
        if (req_valid !== 4'b0001 || res !== 32'd42 || req_err !== 1'b0 || req_busy !== 4'b0000)
          begin n_fail++; $display("FAIL single_done: valid=%b res=%0d err=%b busy=%b, expected 0001/42/0/0000",
            req_valid, res, req_err, req_busy); end
      end
      if (k == 7) begin
        n_checks++;
        if (req_valid !== 4'b0000 || req_busy !== 4'b0000 || res !== 32'd42)
          begin n_fail++; $display("FAIL single_after: valid=%b busy=%b res=%0d, expected 0000/0000/42", req_valid, req_busy, res); end
      end
    end
  endtask

  task automatic test_simultaneous();
    int ncomp, nis;
    logic [W-1:0] iss [8];
    logic [N-1:0] exp_v;
    ncomp = 0; nis = 0;
    do_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) set_ops(i, i + 1, 10);
    req_start = '1;
    for (int k = 0; k < 80 && ncomp < N; k++) begin
      @(negedge clk);
      req_start = '0;
      if (unit_start === 1'b1 && nis < 8) begin iss[nis] = unit_a; nis++; end
      if (req_valid !== '0) begin
        exp_v = N'(1) << ncomp;
        n_checks++;
        if (req_valid !== exp_v || res !== W'((ncomp + 1) * 10))
          begin n_fail++; $display("FAIL simul_result%0d: valid=%b res=%0d, expected %b/%0d",
            ncomp, req_valid, res, exp_v, (ncomp + 1) * 10); end
        n_checks++;
        if (unit_start !== 1'b0)
          begin n_fail++; $display("FAIL simul_spacing%0d: unit_start=%b with req_valid, expected 0", ncomp, unit_start); end
        ncomp++;
      end
    end
    n_checks++;
    if (ncomp != N) begin n_fail++; $display("FAIL simul_count: got %0d completions, expected %0d", ncomp, N); end
    n_checks++;
    if (nis != N || iss[0] !== 32'd1 || iss[1] !== 32'd2 || iss[2] !== 32'd3 || iss[3] !== 32'd4)
      begin n_fail++; $display("FAIL simul_order: %0d issues, first a=%0d,%0d,%0d,%0d expected 1,2,3,4",
        nis, iss[0], iss[1], iss[2], iss[3]); end
  endtask

  task automatic test_fairness();
    int ncomp, who, exp_who;
    logic [W-1:0] exp_res;
    ncomp = 0;
    do_reset();
    @(negedge clk);
    set_ops(0, 3, 5); set_ops(2, 4, 9);
    req_start = 4'b0101;
    for (int k = 0; k < 120 && ncomp < 6; k++) begin
      @(negedge clk);
      req_start = '0;
      if (req_valid !== '0) begin
        who = -1;
        for (int i = 0; i < N; i++) if (req_valid[i]) who = i;
        exp_who = (ncomp % 2 == 0) ? 0 : 2;
        exp_res = (exp_who == 0) ? 32'd15 : 32'd36;
        n_checks++;
        if (who != exp_who || res !== exp_res)
          begin n_fail++; $display("FAIL fair_grant%0d: requester %0d res=%0d, expected %0d/%0d",
            ncomp, who, res, exp_who, exp_res); end
        req_start = req_valid & 4'b0101;
        ncomp++;
      end
    end
    n_checks++;
    if (ncomp != 6) begin n_fail++; $display("FAIL fair_count: got %0d grants, expected 6", ncomp); end
  endtask

  task automatic test_busy_overlap();
    int nres, acc_k;
    logic [W-1:0] r [4];
    nres = 0; acc_k = -1;
    do_reset();
    @(negedge clk);
    set_ops(1, 5, 6); req_start = 4'b0010;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      req_start = '0;
      if (k == 3) begin
        n_checks++;
        if (req_busy[1] !== 1'b1)
          begin n_fail++; $display("FAIL busy_flag: req_busy[1]=%b, expected 1", req_busy[1]); end
        set_ops(1, 9, 9); req_start = 4'b0010;
      end
      if (k == acc_k) begin
        n_checks++;
        if (req_busy[1] !== 1'b1)
          begin n_fail++; $display("FAIL overlap_accept: req_busy[1]=%b after overlap start, expected 1", req_busy[1]); end
      end
      if (req_valid[1] === 1'b1) begin
        if (nres < 4) r[nres] = res;
        if (nres == 0) begin set_ops(1, 2, 8); req_start = 4'b0010; acc_k = k + 1; end
        nres++;
      end
    end
    n_checks++;
    if (nres != 2 || r[0] !== 32'd30 || r[1] !== 32'd16)
      begin n_fail++; $display("FAIL busy_results: %0d results first=%0d second=%0d, expected 2 results 30,16",
        nres, r[0], r[1]); end
  endtask

  task automatic test_unit_busy_reset();
    bit saw, found, bad;
    saw = 0; found = 0; bad = 0;
    do_reset();
    @(negedge clk);
    unit_busy = 1'b1;
    set_ops(3, 2, 2); req_start = 4'b1000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req_start = '0;
      if (unit_start === 1'b1) saw = 1;
    end
    n_checks++;
    if (saw || req_busy !== 4'b1000)
      begin n_fail++; $display("FAIL unit_busy_hold: start_seen=%0b busy=%b, expected 0/1000", saw, req_busy); end
    unit_busy = 1'b0; unit_lat = 20;
    for (int k = 0; k < 5 && !found; k++) begin
      @(negedge clk);
      if (unit_start === 1'b1) found = 1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL unit_busy_release: unit_start seen=%0b, expected 1", found); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({req_busy, req_valid, req_err, res, unit_a, unit_b, unit_start} !== '0)
      begin n_fail++; $display("FAIL midop_reset: busy=%b valid=%b err=%b res=%0d a=%0d b=%0d start=%b, expected all 0",
        req_busy, req_valid, req_err, res, unit_a, unit_b, unit_start); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; unit_lat = 3;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (req_valid !== '0 || unit_start !== 1'b0 || req_busy !== '0) bad = 1;
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL post_reset_quiet: activity after reset=%0b, expected 0", bad); end
    set_ops(2, 7, 3); req_start = 4'b0100;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      req_start = '0;
      if (req_valid !== '0) begin
        found = 1;
        n_checks++;
        if (req_valid !== 4'b0100 || res !== 32'd21)
          begin n_fail++; $display("FAIL post_reset_op: valid=%b res=%0d, expected 0100/21", req_valid, res); end
      end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL post_reset_timeout: no completion, expected one"); end
  endtask

`ifdef MUL_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    do_reset();
    @(negedge clk);
    unit_hang = 1'b1;
    set_ops(0, 5, 5); set_ops(1, 11, 2);
    req_start = 4'b0011;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      req_start = '0;
      if (k == 10) begin
        n_checks++;
        if (req_valid !== 4'b0000)
          begin n_fail++; $display("FAIL wd_early: valid=%b, expected 0000", req_valid); end
      end
      if (k == 11) begin
        n_checks++;
        if (req_valid !== 4'b0001 || req_err !== 1'b1 || res !== '0)
          begin n_fail++; $display("FAIL wd_abort: valid=%b err=%b res=%0d, expected 0001/1/0", req_valid, req_err, res); end
        unit_hang = 1'b0;
      end
      if (k == 12) begin
        n_checks++;
        if (unit_start !== 1'b1 || unit_a !== 32'd11)
          begin n_fail++; $display("FAIL wd_next_issue: start=%b a=%0d, expected 1/11", unit_start, unit_a); end
      end
      if (k == 16) begin
        n_checks++;
        if (req_valid !== 4'b0010 || req_err !== 1'b0 || res !== 32'd22)
          begin n_fail++; $display("FAIL wd_next_done: valid=%b err=%b res=%0d, expected 0010/0/22", req_valid, req_err, res); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_busy_overlap();
    test_unit_busy_reset();
`ifdef MUL_ARB_WATCHDOG_EN
    test_watchdog();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
